// File: rtl/adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// adc_capture_ctrl
//
// Capture sequencer between the ADC deserializer and an AXI-stream master.
// Software arms the block; a software or external trigger starts capture.
// Dual-channel samples are sign-extended and packed into one beat each, and
// frames of len beats are streamed out with tlast on the final beat. A small
// first-word-fall-through FIFO absorbs tready back-pressure; samples that do
// not fit are dropped and counted.
//
// Ports:
//   m_axis_aclk      ADC-domain clock (single clock domain)
//   m_axis_aresetn   asynchronous active-low reset
//   cfg_enable       block enable; low aborts an armed or running capture
//   cfg_arm          one-cycle arm command (honoured only in IDLE)
//   cfg_continuous   keep producing back-to-back frames while set
//   cfg_trig_sel     0 = sw_trigger, 1 = ext_trigger
//   cfg_frame_len    beats per frame; 0 makes arm a no-op
//   sw_trigger       one-cycle synchronous trigger
//   ext_trigger      asynchronous trigger, rising edge active
//   adc_valid        sample strobe
//   adc_data_a/b     two's complement channel samples
//   m_axis_*         AXI-stream master; tdata = {sext(b), sext(a)}
//   status_state     00 IDLE, 01 ARMED, 10 CAPTURE, 11 DRAIN
//   overflow_cnt     dropped samples, saturating
//   frame_cnt        completed (tlast-handshaked) frames, wrapping
//   abort_flag       sticky abort indication, cleared by the next accepted arm
// -----------------------------------------------------------------------------
module adc_capture_ctrl #(
    parameter int unsigned DATA_WIDTH  = 14,
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH  = 16,   // power of 2, at least 4
    parameter int unsigned LEN_WIDTH   = 16
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    input  logic                   cfg_enable,
    input  logic                   cfg_arm,
    input  logic                   cfg_continuous,
    input  logic                   cfg_trig_sel,
    input  logic [LEN_WIDTH-1:0]   cfg_frame_len,
    input  logic                   sw_trigger,
    input  logic                   ext_trigger,
    input  logic                   adc_valid,
    input  logic [DATA_WIDTH-1:0]  adc_data_a,
    input  logic [DATA_WIDTH-1:0]  adc_data_b,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [1:0]             status_state,
    output logic [LEN_WIDTH-1:0]   overflow_cnt,
    output logic [LEN_WIDTH-1:0]   frame_cnt,
    output logic                   abort_flag
);

    localparam int unsigned HALF_WIDTH  = TDATA_WIDTH / 2;
    localparam int unsigned EXT_WIDTH   = HALF_WIDTH - DATA_WIDTH;
    localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_WIDTH = TDATA_WIDTH + 1;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ARMED   = 2'b01;
    localparam logic [1:0] ST_CAPTURE = 2'b10;
    localparam logic [1:0] ST_DRAIN   = 2'b11;

    // -------------------------------------------------------------------------
    // External trigger: 2-flop synchronizer, edge detector, registered pulse.
    // The pulse is visible to the FSM three cycles after the input edge.
    // -------------------------------------------------------------------------
    logic ext_sync1_q;
    logic ext_sync2_q;
    logic ext_prev_q;
    logic ext_pulse_q;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            ext_sync1_q <= 1'b0;
            ext_sync2_q <= 1'b0;
            ext_prev_q  <= 1'b0;
            ext_pulse_q <= 1'b0;
        end else begin
            ext_sync1_q <= ext_trigger;
            ext_sync2_q <= ext_sync1_q;
            ext_prev_q  <= ext_sync2_q;
            ext_pulse_q <= ext_sync2_q & ~ext_prev_q;
        end
    end

    logic trig_pulse;
    assign trig_pulse = cfg_trig_sel ? ext_pulse_q : sw_trigger;

    // -------------------------------------------------------------------------
    // State and shared control
    // -------------------------------------------------------------------------
    logic [1:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 abort_q, abort_d;

    logic                   tvalid_q;
    logic [TDATA_WIDTH-1:0] tdata_q;
    logic                   tlast_q;

    logic [PTR_WIDTH:0]     wr_ptr_q;
    logic [PTR_WIDTH:0]     rd_ptr_q;
    logic [ENTRY_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic out_take;
    logic handshake;
    logic flush;
    logic fifo_rd;
    logic sample;
    logic fifo_wr;
    logic drop;
    logic beat_last;

    logic [TDATA_WIDTH-1:0] packed_beat;
    logic [ENTRY_WIDTH-1:0] fifo_head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                        (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_q[PTR_WIDTH-1:0]];

    // Output register can accept a new beat when empty or being drained now.
    assign out_take  = !tvalid_q || m_axis_tready;
    assign handshake = tvalid_q && m_axis_tready;

    // Enable dropping mid-capture discards everything still queued.
    assign flush = (state_q == ST_CAPTURE) && !cfg_enable;

    assign fifo_rd = !fifo_empty && out_take && !flush;
    assign sample  = (state_q == ST_CAPTURE) && cfg_enable && adc_valid;
    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    assign fifo_wr = sample && (!fifo_full || fifo_rd);
    assign drop    = sample && fifo_full && !fifo_rd;

    assign beat_last = (beat_cnt_q == (len_q - LEN_WIDTH'(1)));

    assign packed_beat = {{EXT_WIDTH{adc_data_b[DATA_WIDTH-1]}}, adc_data_b,
                          {EXT_WIDTH{adc_data_a[DATA_WIDTH-1]}}, adc_data_a};

    // -------------------------------------------------------------------------
    // Capture FIFO (first-word-fall-through). Storage needs no reset; the
    // pointers define what is valid.
    // -------------------------------------------------------------------------
    always_ff @(posedge m_axis_aclk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q[PTR_WIDTH-1:0]] <= {beat_last, packed_beat};
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            // Writes and reads are both blocked during a flush.
            rd_ptr_q <= wr_ptr_q;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered output stage. Data and last only change on a load, so they
    // stay stable while a beat is stalled.
    // -------------------------------------------------------------------------
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else if (fifo_rd) begin
            tvalid_q <= 1'b1;
            tdata_q  <= fifo_head[TDATA_WIDTH-1:0];
            tlast_q  <= fifo_head[TDATA_WIDTH];
        end else if (handshake) begin
            tvalid_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        abort_d    = abort_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_arm && cfg_enable && (cfg_frame_len != '0)) begin
                    state_d    = ST_ARMED;
                    len_d      = cfg_frame_len;
                    beat_cnt_d = '0;
                    abort_d    = 1'b0;
                end
            end
            ST_ARMED: begin
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                end else if (trig_pulse) begin
                    state_d    = ST_CAPTURE;
                    beat_cnt_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (flush) begin
                    abort_d = 1'b1;
                    state_d = ST_DRAIN;
                end else if (fifo_wr) begin
                    // Dropped samples never advance the count, so every
                    // frame carries exactly len beats.
                    if (beat_last) begin
                        beat_cnt_d = '0;
                        if (!cfg_continuous) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !tvalid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            abort_q    <= abort_d;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics
    // -------------------------------------------------------------------------
    logic [LEN_WIDTH-1:0] overflow_q;
    logic [LEN_WIDTH-1:0] frame_q;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            overflow_q <= '0;
            frame_q    <= '0;
        end else begin
            if (drop && (overflow_q != '1)) begin
                overflow_q <= overflow_q + LEN_WIDTH'(1);
            end
            if (handshake && tlast_q) begin
                frame_q <= frame_q + LEN_WIDTH'(1);
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign status_state  = state_q;
    assign overflow_cnt  = overflow_q;
    assign frame_cnt     = frame_q;
    assign abort_flag    = abort_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for adc_capture_ctrl: directed scenarios plus a randomized phase,
// all checked every cycle against a queue-based behavioural model.
// -----------------------------------------------------------------------------
module tb_adc_capture_ctrl;

    localparam int DW    = 14;
    localparam int TW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_enable, cfg_arm, cfg_continuous, cfg_trig_sel;
    logic [LW-1:0] cfg_frame_len;
    logic          sw_trigger, ext_trigger, adc_valid;
    logic [DW-1:0] adc_data_a, adc_data_b;
    logic [TW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [1:0]    status_state;
    logic [LW-1:0] overflow_cnt, frame_cnt;
    logic          abort_flag;

    always #5 clk = ~clk;

    adc_capture_ctrl #(
        .DATA_WIDTH (DW),
        .TDATA_WIDTH(TW),
        .FIFO_DEPTH (DEPTH),
        .LEN_WIDTH  (LW)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_aresetn(rst_n),
        .cfg_enable    (cfg_enable),
        .cfg_arm       (cfg_arm),
        .cfg_continuous(cfg_continuous),
        .cfg_trig_sel  (cfg_trig_sel),
        .cfg_frame_len (cfg_frame_len),
        .sw_trigger    (sw_trigger),
        .ext_trigger   (ext_trigger),
        .adc_valid     (adc_valid),
        .adc_data_a    (adc_data_a),
        .adc_data_b    (adc_data_b),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .status_state  (status_state),
        .overflow_cnt  (overflow_cnt),
        .frame_cnt     (frame_cnt),
        .abort_flag    (abort_flag)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    // States: 0 idle, 1 armed, 2 capture, 3 drain.
    int            m_state;
    logic [LW-1:0] m_len, m_beat, m_ovf, m_frames;
    bit            m_abort, m_ov, m_ol;
    logic [TW-1:0] m_od;
    logic [TW:0]   m_fifo[$];
    bit            ext_hist[4];   // ext_hist[i] = ext_trigger i+1 cycles ago

    task automatic model_reset();
        m_state = 0; m_len = '0; m_beat = '0; m_ovf = '0; m_frames = '0;
        m_abort = 0; m_ov = 0; m_ol = 0; m_od = '0;
        m_fifo.delete();
        for (int i = 0; i < 4; i++) ext_hist[i] = 0;
    endtask

    function automatic logic [15:0] sext(input logic [DW-1:0] v);
        int s;
        s = (int'(v) >= 8192) ? int'(v) - 16384 : int'(v);
        return 16'(s);
    endfunction

    function automatic logic [TW-1:0] pack(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {sext(b), sext(a)};
    endfunction

    task automatic model_step();
        bit trig, flush, hs, rd, smp, room, wr, drop, drained;
        trig    = cfg_trig_sel ? (ext_hist[2] && !ext_hist[3]) : sw_trigger;
        flush   = (m_state == 2) && !cfg_enable;
        hs      = m_ov && m_axis_tready;
        drained = (m_fifo.size() == 0) && !m_ov;
        rd      = (m_fifo.size() > 0) && (!m_ov || m_axis_tready) && !flush;
        smp     = (m_state == 2) && cfg_enable && adc_valid;
        room    = (m_fifo.size() < DEPTH) || rd;
        wr      = smp && room;
        drop    = smp && !room;

        if (hs && m_ol) m_frames = m_frames + 1'b1;
        if (rd) begin
            {m_ol, m_od} = m_fifo.pop_front();
            m_ov = 1;
        end else if (hs) begin
            m_ov = 0;
        end
        if (flush) m_fifo.delete();
        if (wr) m_fifo.push_back({(m_beat == m_len - 1'b1), pack(adc_data_a, adc_data_b)});
        if (drop && m_ovf != 16'hFFFF) m_ovf = m_ovf + 1'b1;

        case (m_state)
            0: if (cfg_arm && cfg_enable && cfg_frame_len != 0) begin
                m_state = 1; m_len = cfg_frame_len; m_beat = '0; m_abort = 0;
            end
            1: if (!cfg_enable) m_state = 0;
               else if (trig) begin m_state = 2; m_beat = '0; end
            2: if (flush) begin
                m_abort = 1; m_state = 3;
            end else if (wr) begin
                if (m_beat == m_len - 1'b1) begin
                    m_beat = '0;
                    if (!cfg_continuous) m_state = 3;
                end else begin
                    m_beat = m_beat + 1'b1;
                end
            end
            default: if (drained) m_state = 0;
        endcase

        for (int i = 3; i > 0; i--) ext_hist[i] = ext_hist[i-1];
        ext_hist[0] = ext_trigger;
    endtask

    task automatic compare_all();
        check("state", 64'(status_state), 64'(m_state));
        check("tvalid", 64'(m_axis_tvalid), 64'(m_ov));
        if (m_ov) begin
            check("tdata", 64'(m_axis_tdata), 64'(m_od));
            check("tlast", 64'(m_axis_tlast), 64'(m_ol));
        end
        check("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
        check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
        check("abort_flag", 64'(abort_flag), 64'(m_abort));
    endtask

    // ---------------------------------------------------------------- drivers
    int            cyc = 0;
    int            beats_seen = 0;
    int            lasts_seen = 0;
    bit            got_first = 0;
    logic [TW-1:0] first_data;

    // Inputs are changed at the falling edge; handshakes observed just before
    // the rising edge come straight from the DUT pins.
    task automatic tick();
        if (m_axis_tvalid && m_axis_tready) begin
            beats_seen++;
            if (m_axis_tlast) lasts_seen++;
            if (!got_first) begin
                got_first  = 1;
                first_data = m_axis_tdata;
            end
        end
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input bit v, input int ready_pct);
        adc_valid     = v;
        adc_data_a    = DW'($urandom);
        adc_data_b    = DW'($urandom);
        m_axis_tready = (int'($urandom_range(99)) < ready_pct);
    endtask

    task automatic arm(input int len, input bit cont, input bit tsel);
        cfg_frame_len  = LW'(len);
        cfg_continuous = cont;
        cfg_trig_sel   = tsel;
        cfg_arm        = 1;
        drive(0, 100);
        tick();
        cfg_arm = 0;
    endtask

    task automatic sw_trig();
        sw_trigger = 1;
        drive(1, 100);
        tick();
        sw_trigger = 0;
    endtask

    // Bounded wait for IDLE with the output drained; kicks a stuck ARMED state.
    task automatic wait_idle();
        cfg_continuous = 0;
        cfg_trig_sel   = 0;
        cfg_enable     = 1;
        for (int i = 0; i < 800; i++) begin
            if (status_state == 2'b00 && !m_axis_tvalid) break;
            sw_trigger = 1;
            drive($urandom_range(1), 100);
            tick();
        end
        sw_trigger = 0;
        check("reach_idle", 64'(status_state), 64'(0));
    endtask

    task automatic check_reset_outputs();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_tdata", 64'(m_axis_tdata), 64'(0));
        check("rst_tlast", 64'(m_axis_tlast), 64'(0));
        check("rst_state", 64'(status_state), 64'(0));
        check("rst_overflow", 64'(overflow_cnt), 64'(0));
        check("rst_frames", 64'(frame_cnt), 64'(0));
        check("rst_abort", 64'(abort_flag), 64'(0));
    endtask

    // --------------------------------------------------------------- sequence
    initial begin
        int b0, l0, k_edge;
        logic [LW-1:0] f0, o0;

        rst_n = 0;
        cfg_enable = 0; cfg_arm = 0; cfg_continuous = 0; cfg_trig_sel = 0;
        cfg_frame_len = '0; sw_trigger = 0; ext_trigger = 0;
        adc_valid = 0; adc_data_a = '0; adc_data_b = '0; m_axis_tready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1;
        cfg_enable = 1;

        // Single software-triggered frame of 8, no back-pressure.
        b0 = beats_seen; l0 = lasts_seen;
        arm(8, 0, 0);
        sw_trig();
        for (int i = 0; i < 12; i++) begin drive(1, 100); tick(); end
        wait_idle();
        check("t1_beats", 64'(beats_seen - b0), 64'(8));
        check("t1_lasts", 64'(lasts_seen - l0), 64'(1));
        check("t1_frames", 64'(frame_cnt), 64'(1));
        check("t1_overflow", 64'(overflow_cnt), 64'(0));

        // Sign-extension packing.
        arm(1, 0, 0);
        sw_trig();
        drive(1, 0);
        adc_data_a = 14'h2000;
        adc_data_b = 14'h1FFF;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (m_axis_tvalid) break;
            drive(0, 0);
            tick();
        end
        check("t2_tdata", 64'(m_axis_tdata), 64'h1FFF_E000);
        wait_idle();

        // Back-pressure: 40 stalled cycles; FIFO plus output register hold
        // DEPTH+1 beats and every further sample in the stall is dropped.
        b0 = beats_seen; l0 = lasts_seen; o0 = overflow_cnt;
        arm(64, 0, 0);
        sw_trig();
        for (int i = 0; i < 40; i++) begin drive(1, 0); tick(); end
        for (int i = 0; i < 80; i++) begin drive(1, 100); tick(); end
        wait_idle();
        check("t3_beats", 64'(beats_seen - b0), 64'(64));
        check("t3_lasts", 64'(lasts_seen - l0), 64'(1));
        check("t3_drops", 64'(overflow_cnt - o0), 64'(40 - (DEPTH + 1)));

        // External trigger: first beat is the sample 4 cycles after the edge;
        // a software trigger with ext selected and a second edge are ignored.
        b0 = beats_seen; l0 = lasts_seen;
        arm(32, 0, 1);
        got_first = 0;
        sw_trigger = 1; drive(1, 100); tick(); sw_trigger = 0;
        for (int i = 0; i < 3; i++) begin drive(1, 100); tick(); end
        check("t4_sw_ignored", 64'(status_state), 64'(1));
        k_edge = cyc;
        for (int i = 0; i < 60; i++) begin
            ext_trigger = !(i >= 12 && i < 16);
            drive(1, 100);
            adc_data_a = DW'(cyc);
            adc_data_b = '0;
            tick();
        end
        ext_trigger = 0;
        wait_idle();
        check("t4_first_beat", 64'(first_data), 64'({16'h0, 16'(k_edge + 4)}));
        check("t4_beats", 64'(beats_seen - b0), 64'(32));
        check("t4_lasts", 64'(lasts_seen - l0), 64'(1));

        // Continuous mode cleared during the third frame.
        b0 = beats_seen; l0 = lasts_seen; f0 = frame_cnt;
        arm(4, 1, 0);
        sw_trig();
        for (int i = 0; i < 12; i++) begin
            if (i == 9) cfg_continuous = 0;
            drive(1, 100);
            tick();
        end
        wait_idle();
        check("t5_beats", 64'(beats_seen - b0), 64'(12));
        check("t5_lasts", 64'(lasts_seen - l0), 64'(3));
        check("t5_frames", 64'(frame_cnt - f0), 64'(3));

        // Abort after 5 writes under back-pressure: pending beat is held.
        b0 = beats_seen; l0 = lasts_seen;
        arm(16, 0, 0);
        sw_trigger = 1; drive(1, 0); tick(); sw_trigger = 0;
        for (int i = 0; i < 5; i++) begin drive(1, 0); tick(); end
        cfg_enable = 0;
        for (int i = 0; i < 5; i++) begin drive(1, 0); tick(); end
        check("t6_abort", 64'(abort_flag), 64'(1));
        check("t6_held", 64'(m_axis_tvalid), 64'(1));
        check("t6_drain", 64'(status_state), 64'(3));
        wait_idle();
        check("t6_beats", 64'(beats_seen - b0), 64'(1));
        check("t6_no_last", 64'(lasts_seen - l0), 64'(0));

        // Reset in the middle of a capture clears everything at once.
        arm(16, 0, 0);
        sw_trig();
        for (int i = 0; i < 6; i++) begin drive(1, 50); tick(); end
        #2 rst_n = 0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Randomized episodes.
        for (int ep = 0; ep < 30; ep++) begin
            int vpct, rpct;
            vpct = $urandom_range(30, 100);
            rpct = $urandom_range(20, 100);
            arm(($urandom_range(7) == 0) ? 0 : $urandom_range(1, 20),
                ($urandom_range(2) == 0), $urandom_range(1));
            for (int i = 0; i < 150; i++) begin
                cfg_enable  = ($urandom_range(199) != 0);
                cfg_arm     = ($urandom_range(49) == 0);
                sw_trigger  = ($urandom_range(9) == 0);
                if ($urandom_range(7) == 0) ext_trigger = !ext_trigger;
                if (i == 100 && $urandom_range(1) == 1) cfg_continuous = 0;
                drive(int'($urandom_range(99)) < vpct, rpct);
                tick();
            end
            cfg_arm = 0; sw_trigger = 0; cfg_enable = 1;
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
